// File: rtl/bcd6311_to_xs3_packer_if.sv
// Digit-in / word-out valid-ready bundle for bcd6311_to_xs3_packer.
// The master modport is the environment (digit source plus word consumer); slave is the packer.
interface bcd6311_to_xs3_packer_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            in_digit;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_word;
    logic                  out_err;

    modport master (
        output in_valid,
        output in_digit,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_word,
        input  out_err
    );

    modport slave (
        input  in_valid,
        input  in_digit,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_word,
        output out_err
    );
endinterface

// File: rtl/bcd6311_to_xs3_packer.sv
// Streams BCD 6-3-1-1 digits in, packs DIGITS Excess-3 nibbles per word (MSD first).
// Optional saturating invalid-digit counter enabled by BCD6311_ERR_CNT_EN.
module bcd6311_to_xs3_packer #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_clr,
    bcd6311_to_xs3_packer_if.slave        bus
`ifdef BCD6311_ERR_CNT_EN
    ,
    output logic [7:0]                    o_err_count
`endif
);

    typedef enum logic [0:0] {StCollect, StHold} state_e;

    localparam logic [3:0] LastCnt = 4'(DIGITS - 1);

    state_e                r_state;
    logic [4*DIGITS-1:0]   r_word;
    logic                  r_err;
    logic [3:0]            r_cnt;

    state_e                w_state_nxt;
    logic [4*DIGITS-1:0]   w_word_nxt;
    logic                  w_err_nxt;
    logic [3:0]            w_cnt_nxt;
    logic [4*DIGITS-1:0]   w_nib_ext;
    logic [4:0]            w_conv;
    logic                  w_accept;

    // Returns {invalid, xs3}; invalid codes map to XS-3 zero.
    function automatic logic [4:0] conv_6311(input logic [3:0] code);
        logic [4:0] res;
        case (code)
            4'b0000: res = 5'b0_0011;
            4'b0001: res = 5'b0_0100;
            4'b0011: res = 5'b0_0101;
            4'b0100: res = 5'b0_0110;
            4'b0101: res = 5'b0_0111;
            4'b0111: res = 5'b0_1000;
            4'b1000: res = 5'b0_1001;
            4'b1001: res = 5'b0_1010;
            4'b1011: res = 5'b0_1011;
            4'b1100: res = 5'b0_1100;
            default: res = 5'b1_0011;
        endcase
        return res;
    endfunction

    assign w_conv   = conv_6311(bus.in_digit);
    assign w_accept = bus.in_valid && (r_state == StCollect);

    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;
        w_nib_ext   = '0;
        w_nib_ext[3:0] = w_conv[3:0];
        if (i_clr) begin
            w_state_nxt = StCollect;
            w_word_nxt  = '0;
            w_err_nxt   = 1'b0;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                StCollect: begin
                    if (w_accept) begin
                        w_word_nxt = (r_word << 4) | w_nib_ext;
                        w_err_nxt  = r_err | w_conv[4];
                        if (r_cnt == LastCnt) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = StHold;
                        end else begin
                            w_cnt_nxt = r_cnt + 4'd1;
                        end
                    end
                end
                StHold: begin
                    if (bus.out_ready) begin
                        w_state_nxt = StCollect;
                        w_err_nxt   = 1'b0;
                    end
                end
                default: w_state_nxt = StCollect;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StCollect;
            r_word  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_word  <= w_word_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign bus.in_ready  = (r_state == StCollect);
    assign bus.out_valid = (r_state == StHold);
    assign bus.out_word  = r_word;
    assign bus.out_err   = r_err;

`ifdef BCD6311_ERR_CNT_EN
    logic [7:0] r_err_count;

    // Survives clr on purpose; only reset clears it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_count <= '0;
        end else if (w_accept && !i_clr && w_conv[4] && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign o_err_count = r_err_count;
`endif

endmodule

// File: doc/bcd6311_to_xs3_packer.md
# bcd6311_to_xs3_packer

Streaming converter from BCD 6-3-1-1 digits to Excess-3, the reverse direction of the XS-3 → 6-3-1-1 code converter. It accepts one 6-3-1-1 digit per valid/ready transfer, most significant digit first, converts each digit to XS-3 and packs DIGITS of them into one word. The word is held on a valid/ready output port until the consumer accepts it. It sits between a digit-serial source (keypad/display side) and word-wide XS-3 arithmetic logic.

## Interface
- DIGITS, 4: digits per output word; legal range 1..8.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- clr  input  1  synchronous clear; discards the partial word and any pending output word.
- in_valid  input  1  in_digit is valid.
- in_ready  output  1  block can accept a digit this cycle.
- in_digit  input  4  6-3-1-1 code.
- out_valid  output  1  out_word/out_err are valid.
- out_ready  input  1  consumer accepts the word.
- out_word  output  4*DIGITS  XS-3 word; first-received digit in [4*DIGITS-1 -: 4].
- out_err  output  1  at least one digit of out_word was an invalid code.
- err_count  output  8  only with BCD6311_ERR_CNT_EN; see Configuration.

## Operation
- Canonical code map (6-3-1-1 → value): 0000→0, 0001→1, 0011→2, 0100→3, 0101→4, 0111→5, 1000→6, 1001→7, 1011→8, 1100→9. The XS-3 result is value+3, 4 bits.
- Invalid codes are 0010, 0110, 1010, 1101, 1110 and 1111. Non-canonical aliases (0010, 0110, 1010) are invalid. An invalid code converts to 0011 (XS-3 zero) and sets the word's error flag.
- FSM states:
  - COLLECT: in_ready=1, out_valid=0.
    - Each in_valid&&in_ready transfer shifts the converted nibble into the word register (left shift, new nibble at LSB), ORs its invalid flag into err, and increments the digit counter.
    - On the DIGITS-th transfer the counter resets to 0 and the FSM moves to HOLD.
  - HOLD: in_ready=0, out_valid=1; out_word and out_err are stable.
    - On out_valid&&out_ready the FSM moves to COLLECT and err clears.
- in_ready is a pure function of state; it does not depend on out_ready. A digit is never accepted in HOLD.
- clr has priority over every other event. In the next cycle the FSM is in COLLECT, the counter is 0, err is 0 and the word register is 0. If a word was pending, it is dropped. A digit presented in the clr cycle is discarded.
- Reset (asynchronous, any time, including mid-word or mid-HOLD) produces the same state as clr.
- Reset values: in_ready=1, out_valid=0, out_word=0, out_err=0, err_count=0.

## Timing
- Conversion is combinational from in_digit into the word register. There is no extra pipeline stage.
- out_valid rises on the clock edge that captures the last digit of the word (latency 1 edge after the final transfer).
- Minimum period per word is DIGITS+1 cycles: DIGITS transfer cycles plus one HOLD cycle with out_ready=1.
- Under backpressure (out_ready=0), HOLD persists indefinitely and outputs do not change.
- DIGITS=1: every transfer goes COLLECT→HOLD directly.

## Configuration
- BCD6311_ERR_CNT_EN defined:
  - err_count (8 bits) increments once per accepted invalid digit.
  - It saturates at 255 and does not wrap.
  - It is cleared by reset only, not by clr.
- Macro undefined: the err_count port and its counter are absent. All other behaviour is identical.

## Test plan
- Normal word (DIGITS=4, out_ready=1): digits 1100,0000,0111,0011 → out_word=16'hC385, out_err=0, out_valid one edge after the 4th transfer.
- Invalid digit: 0001,1111,0100,0101 → out_word=16'h4367, out_err=1; with BCD6311_ERR_CNT_EN, err_count increments by 1.
- All codes: sweep all 16 in_digit values with DIGITS=1 → 10 valid codes give value+3, the 6 invalid codes give 0011 with out_err=1; err_count reads 6 after the sweep.
- Backpressure: out_ready=0 for 5 cycles after a word completes → out_valid=1, in_ready=0, out_word stable. in_valid stays high during those cycles and no digit is consumed. Collection resumes the cycle after out_ready=1.
- Reset mid-word: assert rst_n=0 asynchronously after 2 digits → outputs go to reset values immediately. The next 4 digits 0001,0011,0100,0101 yield 16'h4567.
- clr in HOLD: clr=1 with a pending word → out_valid=0 and in_ready=1 next cycle. The pending word is never accepted, and err_count is unchanged.
